wb_bus_arbiter: RTL and testbench

Shares the node-side Wishbone bus between N_MASTERS masters: the NIC noc2wb master and the node's local masters. It produces the per-master grant whose bit 0 drives the NIC's gnt_wb_i. Grants are round-robin and are held for a complete CYC cycle. A watchdog revokes a grant when the slave never terminates the cycle.

---
 rtl/wb_bus_arbiter.sv | 118 +++++++++++
 tb/tb_wb_bus_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_bus_arbiter.sv
// Round-robin Wishbone bus arbiter with a per-grant watchdog.
// A grant is held for a whole CYC cycle. A master whose slave never
// terminates the cycle loses the grant. It stays masked until it
// deasserts CYC.
module wb_bus_arbiter #(
  parameter int N_MASTERS      = 4,
  parameter int N_BITS_MASTER  = $clog2(N_MASTERS),
  parameter int TIMEOUT_CYCLES = 255,
  parameter int N_BITS_TIMEOUT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_MASTERS-1:0]     cyc_i,
  input  logic                     ack_i,
  input  logic                     err_i,
  input  logic                     rty_i,
  output logic [N_MASTERS-1:0]     gnt_o,
  output logic [N_BITS_MASTER-1:0] gnt_id_o,
  output logic                     gnt_valid_o,
  output logic                     timeout_o,
  output logic [N_BITS_MASTER-1:0] timeout_id_o
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [N_MASTERS-1:0]      ONE_HOT0 = N_MASTERS'(1);
  localparam logic [N_BITS_TIMEOUT-1:0] WDOG_LAST = N_BITS_TIMEOUT'(TIMEOUT_CYCLES - 1);
  localparam logic [N_BITS_TIMEOUT-1:0] WDOG_MAX  = N_BITS_TIMEOUT'(TIMEOUT_CYCLES);
  localparam logic [N_BITS_MASTER:0]    N_WIDE    = (N_BITS_MASTER + 1)'(N_MASTERS);

  state_t                    state;
  logic [N_BITS_MASTER-1:0]  last_gnt;
  logic [N_MASTERS-1:0]      mask;
  logic [N_BITS_TIMEOUT-1:0] wdog;

  logic [N_MASTERS-1:0]      eligible;
  logic                      found;
  logic [N_BITS_MASTER-1:0]  winner;
  logic [N_BITS_MASTER:0]    sum;
  logic [N_BITS_MASTER-1:0]  cand;
  logic                      term;
  logic                      owner_cyc;

  assign term      = ack_i | err_i | rty_i;
  assign owner_cyc = cyc_i[gnt_id_o];

  // Round-robin pick: first eligible master after last_gnt, wrapping around.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    eligible = cyc_i & ~mask;
    found    = 1'b0;
    winner   = '0;
    sum      = '0;
    cand     = '0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      sum = {1'b0, last_gnt} + (N_BITS_MASTER + 1)'(k);
      if (sum >= N_WIDE) sum = sum - N_WIDE;
      cand = sum[N_BITS_MASTER-1:0];
      if (!found && eligible[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Grant FSM, watchdog counter and revocation mask, all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      state        <= IDLE;
      gnt_o        <= '0;
      gnt_id_o     <= '0;
      gnt_valid_o  <= 1'b0;
      timeout_o    <= 1'b0;
      timeout_id_o <= '0;
      last_gnt     <= N_BITS_MASTER'(N_MASTERS - 1);
      mask         <= '0;
      wdog         <= '0;
    end else begin
      timeout_o <= 1'b0;
      // A master leaves the mask once it has deasserted CYC.
      mask      <= mask & cyc_i;
      case (state)
        IDLE: begin
          if (found) begin
            gnt_o       <= ONE_HOT0 << winner;
            gnt_id_o    <= winner;
            gnt_valid_o <= 1'b1;
            last_gnt    <= winner;
            wdog        <= '0;
            state       <= GRANT;
          end
        end
        GRANT: begin
          if (!owner_cyc) begin
            // Normal end of cycle; the drop takes priority over a timeout.
            gnt_o       <= '0;
            gnt_valid_o <= 1'b0;
            state       <= IDLE;
          end else if (term) begin
            wdog <= '0;
          end else if (wdog == WDOG_LAST) begin
            timeout_o    <= 1'b1;
            timeout_id_o <= gnt_id_o;
            mask         <= (mask & cyc_i) | (ONE_HOT0 << gnt_id_o);
            gnt_o        <= '0;
            gnt_valid_o  <= 1'b0;
            state        <= IDLE;
          end else if (wdog != WDOG_MAX) begin
            wdog <= wdog + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Self-checking bench for wb_bus_arbiter: directed scenarios plus randomized
// traffic, compared every cycle against a behavioural ownership model.
module tb_wb_bus_arbiter;

  localparam int N  = 4;
  localparam int NB = 2;
  localparam int T  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  cyc;
  logic          ack, err, rty;
  logic [N-1:0]  gnt_o;
  logic [NB-1:0] gnt_id_o;
  logic          gnt_valid_o;
  logic          timeout_o;
  logic [NB-1:0] timeout_id_o;

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the bus, how long the slave has been silent,
  // who won last, and which masters are barred after a revocation.
  int owner;
  int last_win;
  int silent;
  bit blocked [N];
  bit exp_to;
  int exp_to_id;

  wb_bus_arbiter #(
    .N_MASTERS(N), .N_BITS_MASTER(NB), .TIMEOUT_CYCLES(T), .N_BITS_TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst), .cyc_i(cyc), .ack_i(ack), .err_i(err), .rty_i(rty),
    .gnt_o(gnt_o), .gnt_id_o(gnt_id_o), .gnt_valid_o(gnt_valid_o),
    .timeout_o(timeout_o), .timeout_id_o(timeout_id_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] exp_gnt();
    if (owner < 0) return '0;
    return N'(1) << owner;
  endfunction

  // One clock edge of the arbitration rules, applied to the inputs present now.
  task automatic model_step();
    bit keep [N];
    if (!rst) begin
      owner = -1; last_win = N - 1; silent = 0; exp_to = 0; exp_to_id = 0;
      for (int i = 0; i < N; i++) blocked[i] = 0;
      return;
    end
    exp_to = 0;
    for (int i = 0; i < N; i++) keep[i] = blocked[i] && cyc[i];
    if (owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int c = (last_win + k) % N;
        if (cyc[c] && !blocked[c]) begin
          owner = c; last_win = c; silent = 0;
          break;
        end
      end
    end else if (!cyc[owner]) begin
      owner = -1;
    end else if (ack || err || rty) begin
      silent = 0;
    end else if (silent == T - 1) begin
      exp_to = 1; exp_to_id = owner; keep[owner] = 1; owner = -1;
    end else if (silent < T) begin
      silent++;
    end
    for (int i = 0; i < N; i++) blocked[i] = keep[i];
  endtask

  // Advance one clock, update the model, then compare all outputs.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("gnt", 32'(gnt_o), 32'(exp_gnt()));
    check("gnt_valid", 32'(gnt_valid_o), 32'(owner >= 0));
    if (owner >= 0) check("gnt_id", 32'(gnt_id_o), 32'(owner));
    check("timeout", 32'(timeout_o), 32'(exp_to));
    check("timeout_id", 32'(timeout_id_o), 32'(exp_to_id));
  endtask

  task automatic do_reset();
    rst = 1'b0; cyc = '0; ack = 0; err = 0; rty = 0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    int order[$];
    int idle_run;
    bit prev_valid;
    int held [N];

    owner = -1; last_win = N - 1; silent = 0; exp_to = 0; exp_to_id = 0;
    for (int i = 0; i < N; i++) blocked[i] = 0;

    // Reset state
    do_reset();
    check("rst_gnt", 32'(gnt_o), 0);
    check("rst_valid", 32'(gnt_valid_o), 0);
    check("rst_gnt_id", 32'(gnt_id_o), 0);

    // Single request, ack held so the watchdog stays quiet.
    ack = 1; cyc = 4'b0100;
    tick();
    check("single_gnt", 32'(gnt_o), 32'h4);
    check("single_id", 32'(gnt_id_o), 2);
    for (int k = 2; k <= 5; k++) tick();
    check("single_held", 32'(gnt_o), 32'h4);
    cyc = 4'b0000;
    tick();
    check("single_drop", 32'(gnt_o), 0);

    // Round robin with all masters requesting.
    do_reset();
    cyc = 4'b1111;
    idle_run = 0; prev_valid = 0;
    for (int i = 0; i < N; i++) held[i] = 0;
    for (int c = 0; c < 40 && order.size() < 5; c++) begin
      tick();
      if (gnt_valid_o && !prev_valid) begin
        if (order.size() > 0) check("rr_gap", 32'(idle_run), 1);
        order.push_back(int'(gnt_id_o));
      end
      idle_run = gnt_valid_o ? 0 : idle_run + 1;
      prev_valid = gnt_valid_o;
      for (int i = 0; i < N; i++) begin
        held[i] = (owner == i) ? held[i] + 1 : 0;
        cyc[i]  = !(owner == i && held[i] == 3);
      end
    end
    check("rr_count", 32'(order.size()), 5);
    for (int i = 0; i < order.size() && i < 5; i++)
      check("rr_order", 32'(order[i]), 32'(i % N));

    // No preemption by a higher-priority request.
    do_reset();
    ack = 1; cyc = 4'b0100;
    tick();
    cyc = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("nopre_hold", 32'(gnt_o), 32'h4);
    end
    cyc = 4'b0001;
    tick();
    check("nopre_idle", 32'(gnt_o), 0);
    tick();
    check("nopre_next", 32'(gnt_o), 32'h1);

    // Watchdog revocation and masking.
    do_reset();
    cyc = 4'b0010;
    tick();
    check("wd_gnt", 32'(gnt_o), 32'h2);
    cyc = 4'b1010;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("wd_quiet", 32'(timeout_o), 0);
    end
    tick();
    check("wd_pulse", 32'(timeout_o), 1);
    check("wd_id", 32'(timeout_id_o), 1);
    check("wd_drop", 32'(gnt_valid_o), 0);
    tick();
    check("wd_pulse_end", 32'(timeout_o), 0);
    check("wd_next", 32'(gnt_o), 32'h8);
    ack = 1; cyc = 4'b0010;
    tick();
    tick();
    tick();
    check("wd_masked", 32'(gnt_valid_o), 0);
    cyc = 4'b0000;
    tick();
    cyc = 4'b0010;
    tick();
    check("wd_regrant", 32'(gnt_o), 32'h2);
    check("wd_id_hold", 32'(timeout_id_o), 1);

    // Acks keep a long grant alive; an ack on the last cycle saves it.
    do_reset();
    cyc = 4'b0001;
    tick();
    for (int k = 0; k < 20; k++) begin
      ack = (k % 3 == 2);
      tick();
      check("alive_to", 32'(timeout_o), 0);
    end
    ack = 1; tick();
    ack = 0; tick(); tick(); tick();
    ack = 1; tick();
    check("late_ack_to", 32'(timeout_o), 0);
    check("late_ack_valid", 32'(gnt_valid_o), 1);
    cyc = 4'b0000; tick();

    // Reset in the middle of a grant.
    do_reset();
    ack = 1; cyc = 4'b1000;
    tick(); tick();
    rst = 0;
    tick();
    check("mid_rst_gnt", 32'(gnt_o), 0);
    check("mid_rst_valid", 32'(gnt_valid_o), 0);
    rst = 1; cyc = 4'b1001;
    tick();
    check("mid_rst_first", 32'(gnt_o), 32'h1);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) != 0);
      ack = ($urandom_range(0, 9) == 0);
      err = ($urandom_range(0, 19) == 0);
      rty = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < N; i++) begin
        if (owner == i)  cyc[i] = ($urandom_range(0, 5) != 0);
        else if (cyc[i]) cyc[i] = ($urandom_range(0, 7) != 0);
        else             cyc[i] = ($urandom_range(0, 2) == 0);
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
